serial_sub_to: RTL and testbench

- Bit-serial 8-bit unsigned subtractor: the subtract-direction counterpart of the 8-bit ripple adder (add_to).
- Computes out = in_1 - in_2 with a single full-subtractor cell and a registered borrow, LSB first, one bit per clock.
- Start/done handshake. Used in the datapath wherever area matters more than latency.

---
 rtl/serial_sub_to.sv | 147 ++++++++++++++
 tb/tb_serial_sub_to.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_sub_to.sv
// Bit-serial 8-bit unsigned subtractor: one full-subtractor cell, LSB first, start/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_to (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_1,
    input  logic [7:0] in_2,
    output logic       busy,
    output logic       done,
`ifdef SERIAL_SUB_OVF_EN
    output logic       ovf,
`endif
    output logic [8:0] out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        br_q, br_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  res_q, res_d;
    logic [8:0]  out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        d_s;
    logic        br_nx_s;
`ifdef SERIAL_SUB_OVF_EN
    logic        msb1_q, msb1_d;
    logic        msb2_q, msb2_d;
    logic        ovf_q, ovf_d;
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            br_q    <= 1'b0;
            cnt_q   <= 3'd0;
            res_q   <= 8'h00;
            out_q   <= 9'h000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            msb1_q  <= 1'b0;
            msb2_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            msb1_q  <= msb1_d;
            msb2_q  <= msb2_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Full-subtractor cell on the current LSBs
    always_comb begin
        d_s     = a_q[0] ^ b_q[0] ^ br_q;
        br_nx_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        msb1_d  = msb1_q;
        msb2_d  = msb2_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_1;
                    b_d     = in_2;
                    br_d    = 1'b0;
                    cnt_d   = 3'd0;
                    res_d   = 8'h00;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    msb1_d  = in_1[7];
                    msb2_d  = in_2[7];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[7:1]};
                b_d   = {1'b0, b_q[7:1]};
                br_d  = br_nx_s;
                res_d = {d_s, res_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                // Last bit: publish the whole result at once so out never shows partials
                if (cnt_q == 3'd7) begin
                    out_d   = {br_nx_s, d_s, res_q[7:1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (msb1_q != msb2_q) && (d_s != msb1_q);
`endif
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_to.sv
// Directed self-checking bench for serial_sub_to; covers ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_to;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic       busy;
    logic       done;
    logic [8:0] out;
    logic       ovf;
    int         n_checks;
    int         n_fails;
    logic [8:0] prev_out;
    logic       prev_ovf;
    int         done_seen;

    serial_sub_to dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_1  (in_1),
        .in_2  (in_2),
        .busy  (busy),
        .done  (done),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .out   (out)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an operation at the current negedge and follows it to its done cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                          input logic exp_ovf, input logic pulse_mid);
        start = 1'b1;
        in_1  = a;
        in_2  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_1  = 8'($urandom);
        in_2  = 8'($urandom);
        check("busy_after_start", {8'h00, busy}, 9'h001);
        check("done_after_start", {8'h00, done}, 9'h000);
        check("out_held_start", out, prev_out);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check("busy_run", {8'h00, busy}, 9'h001);
            check("done_run", {8'h00, done}, 9'h000);
            check("out_held_run", out, prev_out);
            if (pulse_mid && i == 3) begin
                start = 1'b1;
                in_1  = 8'hAA;
                in_2  = 8'h55;
            end
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", {8'h00, done}, 9'h001);
        check("busy_end", {8'h00, busy}, 9'h000);
        check("result", out, exp);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {8'h00, ovf}, {8'h00, exp_ovf});
`endif
        prev_out = exp;
        prev_ovf = exp_ovf;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        prev_out = 9'h000;
        prev_ovf = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        in_1  = 8'h00;
        in_2  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {8'h00, busy}, 9'h000);
        check("reset_done", {8'h00, done}, 9'h000);
        check("reset_out", out, 9'h000);
        check("reset_ovf", {8'h00, ovf}, 9'h000);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run_op(8'd200, 8'd55, 9'h091, 1'b0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", {8'h00, done}, 9'h000);
        check("out_hold_idle", out, 9'h091);
        run_op(8'd5, 8'd7, 9'h1FE, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'd0, 8'd255, 9'h101, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'hFF, 8'hFF, 9'h000, 1'b0, 1'b0);
        @(negedge clk);

        // start during RUN is ignored and yields only one done
        run_op(8'd20, 8'd3, 9'h011, 1'b0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("single_done", 9'(done_seen), 9'h000);
        check("busy_after_ignored", {8'h00, busy}, 9'h000);
        check("out_after_ignored", out, 9'h011);

        // back-to-back: start held through the done cycle
        run_op(8'hFF, 8'h01, 9'h0FE, 1'b0, 1'b0);
        run_op(8'd10, 8'd3, 9'h007, 1'b0, 1'b0);
        @(negedge clk);

        run_op(8'h7F, 8'hFF, 9'h180, 1'b1, 1'b0);
        @(negedge clk);
        run_op(8'h10, 8'h01, 9'h00F, 1'b0, 1'b0);
        @(negedge clk);

        // reset mid-RUN aborts without a done pulse
        start = 1'b1;
        in_1  = 8'd9;
        in_2  = 8'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {8'h00, busy}, 9'h000);
        check("abort_done", {8'h00, done}, 9'h000);
        check("abort_out", out, 9'h000);
        check("abort_ovf", {8'h00, ovf}, 9'h000);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 9'(done_seen), 9'h000);
        check("abort_out_hold", out, 9'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
